// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and geometry helpers for the direct-mapped data cache.
//   dcache_state_t : miss-handling FSM states.
//   off_width / idx_width / tag_width : field widths of a byte address for a
//   given data width, line count and words per line.
//   DC_* : default geometry (32-bit words, 16 lines, 4 words per line).
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } dcache_state_t;

    function automatic int off_width(input int words);
        return $clog2(words);
    endfunction

    function automatic int idx_width(input int lines);
        return $clog2(lines);
    endfunction

    // Two low address bits select a byte inside a word and are not stored.
    function automatic int tag_width(input int n, input int lines, input int words);
        return n - $clog2(lines) - $clog2(words) - 2;
    endfunction

    localparam int DC_N     = 32;
    localparam int DC_LINES = 16;
    localparam int DC_WORDS = 4;
    localparam int DC_OFF_W = off_width(DC_WORDS);
    localparam int DC_IDX_W = idx_width(DC_LINES);
    localparam int DC_TAG_W = tag_width(DC_N, DC_LINES, DC_WORDS);

endpackage

// File: rtl/dcache_array.sv
// dcache_array: tag / valid / dirty / data storage for the data cache.
//   clock, reset_n : clock and asynchronous active-low reset (clears valid/dirty only)
//   index          : line selected for both the read and the write port
//   r_offset       : word offset for the combinational read port
//   line_valid, line_dirty, line_tag : metadata of the selected line
//   r_word         : data word at (index, r_offset)
//   we, w_offset, w_data : word write at (index, w_offset)
//   set_dirty      : mark the selected line dirty (store hit)
//   fill, fill_tag : refill complete: line becomes valid, clean, with fill_tag
module dcache_array
    import dcache_pkg::*;
#(
    parameter int N     = DC_N,
    parameter int LINES = DC_LINES,
    parameter int WORDS = DC_WORDS
) (
    input  logic                                   clock,
    input  logic                                   reset_n,
    input  logic [idx_width(LINES)-1:0]            index,
    input  logic [off_width(WORDS)-1:0]            r_offset,
    output logic                                   line_valid,
    output logic                                   line_dirty,
    output logic [tag_width(N, LINES, WORDS)-1:0]  line_tag,
    output logic [N-1:0]                           r_word,
    input  logic                                   we,
    input  logic [off_width(WORDS)-1:0]            w_offset,
    input  logic [N-1:0]                           w_data,
    input  logic                                   set_dirty,
    input  logic                                   fill,
    input  logic [tag_width(N, LINES, WORDS)-1:0]  fill_tag
);
    localparam int OFF_W = off_width(WORDS);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(N, LINES, WORDS);

    logic [LINES-1:0] valid_bits;
    logic [LINES-1:0] dirty_bits;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [N-1:0]     data_mem [LINES*WORDS];

    // Metadata bits are the only reset state; a reset therefore invalidates
    // every line and drops any dirty data without touching the data array.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_bits <= '0;
            dirty_bits <= '0;
        end else if (fill) begin
            valid_bits[index] <= 1'b1;
            dirty_bits[index] <= 1'b0;
        end else if (set_dirty) begin
            dirty_bits[index] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (we) begin
            data_mem[{index, w_offset}] <= w_data;
        end
        if (fill) begin
            tag_mem[index] <= fill_tag;
        end
    end

    assign line_valid = valid_bits[index];
    assign line_dirty = dirty_bits[index];
    assign line_tag   = tag_mem[index];
    assign r_word     = data_mem[{index, r_offset}];

endmodule

// File: rtl/dcache.sv
// dcache: direct-mapped, write-back, write-allocate data cache.
//   clock, reset_n : clock and asynchronous active-low reset
//   rd, wr         : load / store request, held until stall is low (wr wins)
//   addr, wdata    : byte address and store data
//   rdata          : load data, valid when stall is low and rd is high, else 0
//   stall          : request cannot complete this cycle
//   mem_rd, mem_wr, mem_addr, mem_wdata : word request to main memory
//   mem_rdata, mem_ready : memory read data and per-word completion
//   dbg_state      : current miss-handling state
// Memory handshake: a request (mem_rd or mem_wr with mem_addr/mem_wdata) is
// held unchanged until the cycle mem_ready is high; the word transfers at the
// rising edge closing that cycle. mem_ready is ignored while IDLE.
module dcache
    import dcache_pkg::*;
#(
    parameter int N     = DC_N,
    parameter int LINES = DC_LINES,
    parameter int WORDS = DC_WORDS
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          rd,
    input  logic          wr,
    input  logic [N-1:0]  addr,
    input  logic [N-1:0]  wdata,
    output logic [N-1:0]  rdata,
    output logic          stall,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [N-1:0]  mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ready,
    output dcache_state_t dbg_state
);
    localparam int OFF_W = off_width(WORDS);
    localparam int IDX_W = idx_width(LINES);
    localparam int TAG_W = tag_width(N, LINES, WORDS);
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS - 1);

    dcache_state_t    state, state_next;
    logic [OFF_W-1:0] cnt, cnt_next;

    logic [OFF_W-1:0] req_offset;
    logic [IDX_W-1:0] req_index;
    logic [TAG_W-1:0] req_tag;
    logic             req;
    logic             hit;

    logic             line_valid;
    logic             line_dirty;
    logic [TAG_W-1:0] line_tag;
    logic [N-1:0]     r_word;
    logic [OFF_W-1:0] r_offset;

    logic             arr_we;
    logic [OFF_W-1:0] arr_w_offset;
    logic [N-1:0]     arr_w_data;
    logic             arr_set_dirty;
    logic             arr_fill;

    logic             unused_byte_bits;

    assign req_offset       = addr[2 +: OFF_W];
    assign req_index        = addr[2 + OFF_W +: IDX_W];
    assign req_tag          = addr[N-1 -: TAG_W];
    assign unused_byte_bits = ^addr[1:0];
    assign req              = rd | wr;

    // The held request keeps addressing its line for the whole miss, so the
    // victim and the refilled line share req_index; only the word offset
    // switches to the counter while the victim is being written back.
    assign r_offset = (state == WRITEBACK) ? cnt : req_offset;

    assign hit   = req & line_valid & (line_tag == req_tag) & (state == IDLE);
    assign stall = (req & ~hit) | (state != IDLE);
    assign rdata = (hit & rd & ~wr) ? r_word : '0;
    assign dbg_state = state;

    dcache_array #(
        .N     (N),
        .LINES (LINES),
        .WORDS (WORDS)
    ) u_array (
        .clock      (clock),
        .reset_n    (reset_n),
        .index      (req_index),
        .r_offset   (r_offset),
        .line_valid (line_valid),
        .line_dirty (line_dirty),
        .line_tag   (line_tag),
        .r_word     (r_word),
        .we         (arr_we),
        .w_offset   (arr_w_offset),
        .w_data     (arr_w_data),
        .set_dirty  (arr_set_dirty),
        .fill       (arr_fill),
        .fill_tag   (req_tag)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        arr_we        = 1'b0;
        arr_w_offset  = req_offset;
        arr_w_data    = wdata;
        arr_set_dirty = 1'b0;
        arr_fill      = 1'b0;

        case (state)
            IDLE: begin
                if (hit && wr) begin
                    arr_we        = 1'b1;
                    arr_set_dirty = 1'b1;
                end else if (req && !hit) begin
                    cnt_next   = '0;
                    state_next = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
                end
            end

            WRITEBACK: begin
                mem_wr    = 1'b1;
                mem_addr  = {line_tag, req_index, cnt, 2'b00};
                mem_wdata = r_word;
                if (mem_ready) begin
                    if (cnt == LAST_WORD) begin
                        cnt_next   = '0;
                        state_next = ALLOCATE;
                    end else begin
                        cnt_next = cnt + OFF_W'(1);
                    end
                end
            end

            ALLOCATE: begin
                mem_rd       = 1'b1;
                mem_addr     = {req_tag, req_index, cnt, 2'b00};
                arr_w_offset = cnt;
                arr_w_data   = mem_rdata;
                if (mem_ready) begin
                    arr_we = 1'b1;
                    if (cnt == LAST_WORD) begin
                        // The tag and valid bit are set only with the final
                        // word, so an interrupted refill never looks valid.
                        arr_fill   = 1'b1;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt + OFF_W'(1);
                    end
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache.sv
// tb_dcache: directed bench for dcache with a memory-transaction scoreboard.
module tb_dcache;
    import dcache_pkg::*;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          rd;
    logic          wr;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic          stall;
    logic          mem_rd;
    logic          mem_wr;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          mem_ready;
    dcache_state_t dbg_state;

    int checks = 0;
    int errors = 0;

    // Scoreboard entry: {is_write, word address, write data (0 for reads)}.
    logic [64:0] exp_q[$];

    int          ready_mode = 0;
    int          wcnt = 0;
    logic        pend_prev = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    dcache u_dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd        (rd),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .stall     (stall),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // Main-memory contents are a fixed function of the word address.
    function automatic logic [31:0] pat(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    assign mem_rdata = pat(mem_addr);

    task automatic check(input logic [64:0] obs, input logic [64:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 0: always ready. Mode 1: ready on every 4th cycle of a request.
    always begin
        @(posedge clock);
        #1;
        if (ready_mode == 0) begin
            mem_ready = 1'b1;
            wcnt = 0;
        end else if (mem_rd || mem_wr) begin
            mem_ready = (wcnt == 3);
            wcnt = (wcnt == 3) ? 0 : wcnt + 1;
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Memory-side monitor: completed words are popped from the scoreboard,
    // and a request left waiting must be held unchanged into the next cycle.
    always @(negedge clock) begin
        if (reset_n) begin
            if (pend_prev) begin
                check(65'(mem_addr), 65'(prev_addr), "hold_addr");
                check(65'(mem_rd | mem_wr), 65'd1, "hold_req");
            end
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (exp_q.size() == 0) begin
                    check(65'(exp_q.size()), 65'd1, "unexpected_txn");
                end else begin
                    check({mem_wr, mem_addr, (mem_wr ? mem_wdata : 32'h0)},
                          exp_q.pop_front(), "mem_txn");
                end
            end
            pend_prev = (mem_rd | mem_wr) & ~mem_ready;
            prev_addr = mem_addr;
        end else begin
            pend_prev = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_rd_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({1'b0, base + 32'(i * 4), 32'h0});
        end
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
        exp_q.push_back({1'b1, a, d});
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int exp_stalls, input logic [31:0] exp_rd,
                          input string tag);
        int stalls;
        logic done;
        stalls = 0;
        done = 1'b0;
        rd = ~w;
        wr = w;
        addr = a;
        wdata = d;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (stall) stalls++;
            else done = 1'b1;
        end
        check(65'(done), 65'd1, {tag, "_done"});
        check(65'(stalls), 65'(exp_stalls), {tag, "_stalls"});
        if (!w) check(65'(rdata), 65'(exp_rd), {tag, "_rdata"});
        @(posedge clock);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rd = 1'b0;
        wr = 1'b0;
        addr = 32'h0;
        wdata = 32'h0;
        mem_ready = 1'b1;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check(65'(stall), 65'd0, "rst_stall");
        check(65'(mem_rd), 65'd0, "rst_mem_rd");
        check(65'(mem_wr), 65'd0, "rst_mem_wr");
        check(65'(mem_addr), 65'd0, "rst_mem_addr");
        check(65'(mem_wdata), 65'd0, "rst_mem_wdata");
        check(65'(rdata), 65'd0, "rst_rdata");
        check(65'(dbg_state), 65'(IDLE), "rst_state");
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Clean miss after reset.
        push_rd_line(32'h40);
        access(1'b0, 32'h40, 32'h0, 5, pat(32'h40), "clean_miss");

        // Read hit, then write hit and read-back.
        access(1'b0, 32'h44, 32'h0, 0, pat(32'h44), "read_hit");
        access(1'b1, 32'h48, 32'hDEADBEEF, 0, 32'h0, "write_hit");
        access(1'b0, 32'h48, 32'h0, 0, 32'hDEADBEEF, "read_back");

        // Dirty conflict miss on index 4.
        push_wr(32'h40, pat(32'h40));
        push_wr(32'h44, pat(32'h44));
        push_wr(32'h48, 32'hDEADBEEF);
        push_wr(32'h4C, pat(32'h4C));
        push_rd_line(32'h140);
        access(1'b0, 32'h148, 32'h0, 9, pat(32'h148), "dirty_miss");

        // Refill with memory ready only every 4th cycle.
        ready_mode = 1;
        push_rd_line(32'h280);
        access(1'b0, 32'h28C, 32'h0, 17, pat(32'h28C), "wait_states");
        ready_mode = 0;

        // Store miss: refill, then the store lands as a hit.
        push_rd_line(32'h3C0);
        access(1'b1, 32'h3C4, 32'h12345678, 5, 32'h0, "store_miss");
        access(1'b0, 32'h3C4, 32'h0, 0, 32'h12345678, "store_miss_rb");
        access(1'b0, 32'h3C0, 32'h0, 0, pat(32'h3C0), "store_miss_nb");

        // Reset in the second refill cycle.
        rd = 1'b1;
        addr = 32'h500;
        exp_q.push_back({1'b0, 32'h500, 32'h0});
        @(posedge clock);
        #1;
        check(65'(dbg_state), 65'(ALLOCATE), "mid_alloc_state");
        @(posedge clock);
        #1;
        check(65'(mem_rd), 65'd1, "mid_alloc_rd");
        check(65'(mem_addr), 65'h504, "mid_alloc_addr");
        reset_n = 1'b0;
        #1;
        check(65'(mem_rd), 65'd0, "rst_mid_rd");
        check(65'(mem_addr), 65'd0, "rst_mid_addr");
        check(65'(dbg_state), 65'(IDLE), "rst_mid_state");
        check(65'(stall), 65'd1, "rst_mid_stall");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        push_rd_line(32'h500);
        access(1'b0, 32'h500, 32'h0, 5, pat(32'h500), "reissue");

        // Reset invalidated every line and discarded dirty data.
        push_rd_line(32'h140);
        access(1'b0, 32'h144, 32'h0, 5, pat(32'h144), "inval_clean");
        push_rd_line(32'h3C0);
        access(1'b0, 32'h3C4, 32'h0, 5, pat(32'h3C4), "inval_dirty");

        repeat (2) @(posedge clock);
        check(65'(exp_q.size()), 65'd0, "scoreboard_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
